// File: rtl/rr_mux_select_arbiter.sv
// rr_mux_select_arbiter: round-robin burst-limited arbiter driving the 4:1 mux select
module rr_mux_select_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       burst_done
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] count;
    logic             limit, drop, release_due, found;
    logic [1:0]       start, win;
    logic [3:0]       cand;
    always_comb begin
        limit       = count == CNT_W'(BURST_LEN);
        drop        = !req[sel];
        release_due = (state == GRANT) && (drop || limit || !en);
        start       = (state == GRANT) ? sel + 2'd1 : ptr;
        // a source at its limit stays eligible, but the rotated search reaches it last
        cand        = (state == GRANT && drop) ? req & ~(4'b0001 << sel) : req;
        found       = |cand;
        win         = start;
        for (int i = 3; i >= 0; i--)
            if (cand[start + 2'(i)]) win = start + 2'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            gnt        <= '0;
            gnt_valid  <= 1'b0;
            burst_done <= 1'b0;
            ptr        <= '0;
            count      <= '0;
        end else if (state == IDLE) begin
            burst_done <= 1'b0;
            if (en && found) begin
                sel       <= win;
                gnt       <= 4'b0001 << win;
                gnt_valid <= 1'b1;
                count     <= CNT_W'(1);
                state     <= GRANT;
            end
        end else if (release_due) begin
            ptr        <= sel + 2'd1;
            burst_done <= limit;
            if (en && found) begin
                sel   <= win;
                gnt   <= 4'b0001 << win;
                count <= CNT_W'(1);
            end else begin
                gnt_valid <= 1'b0;
                gnt       <= '0;
                state     <= IDLE;
            end
        end else begin
            count      <= count + CNT_W'(1);
            burst_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// tb_rr_mux_select_arbiter: directed checks of the round-robin arbiter (BURST_LEN=4 and BURST_LEN=1)
module tb_rr_mux_select_arbiter;
    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [3:0] req, req_b;
    logic [1:0] sel, sel_b;
    logic [3:0] gnt, gnt_b;
    logic       gnt_valid, gnt_valid_b, burst_done, burst_done_b;
    int         n_chk = 0;
    int         n_err = 0;

    rr_mux_select_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid), .burst_done(burst_done)
    );
    rr_mux_select_arbiter #(.BURST_LEN(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_b),
        .sel(sel_b), .gnt(gnt_b), .gnt_valid(gnt_valid_b), .burst_done(burst_done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [1:0] s, input logic v, input logic b);
        check({tag, ".sel"}, 32'(sel), 32'(s));
        check({tag, ".gnt"}, 32'(gnt), v ? 32'(4'b0001 << s) : 32'd0);
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        check({tag, ".burst_done"}, 32'(burst_done), 32'(b));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 4'b1111; req_b = 4'b0000;
        repeat (3) tick();
        check_a("reset", 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // full load: 0,1,2,3,0 with 4-cycle bursts and no gap
        for (int i = 0; i < 17; i++) begin
            tick();
            check_a($sformatf("full%0d", i), 2'((i / 4) % 4), 1'b1, i > 0 && i % 4 == 0);
        end
        req = 4'b1010; tick();
        check_a("drop_to1", 2'd1, 1'b1, 1'b0);
        tick();
        check_a("hold1", 2'd1, 1'b1, 1'b0);
        req = 4'b1000; tick();
        check_a("early_drop", 2'd3, 1'b1, 1'b0);
        en = 1'b0; tick();
        check_a("en_off", 2'd3, 1'b0, 1'b0);
        tick();
        check_a("en_off_idle", 2'd3, 1'b0, 1'b0);
        en = 1'b1; req = 4'b0001; tick();
        check_a("en_on", 2'd0, 1'b1, 1'b0);
        req = 4'b0000; tick();
        check_a("to_idle", 2'd0, 1'b0, 1'b0);
        req = 4'b0100; tick();
        check_a("single_lat", 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_a($sformatf("single%0d", i), 2'd2, 1'b1, 1'b0);
        end
        tick();
        check_a("single_regrant", 2'd2, 1'b1, 1'b1);
        tick();
        check_a("single_after", 2'd2, 1'b1, 1'b0);
        // asynchronous reset mid-grant, observed before the next edge
        rst_n = 1'b0; #2;
        check_a("async_rst", 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1; req = 4'b0000; req_b = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("b1_sel%0d", i), 32'(sel_b), 32'(i % 2));
            check($sformatf("b1_gnt%0d", i), 32'(gnt_b), 32'(4'b0001 << (i % 2)));
            check($sformatf("b1_valid%0d", i), 32'(gnt_valid_b), 32'd1);
            check($sformatf("b1_done%0d", i), 32'(burst_done_b), 32'(i > 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rr_mux_select_arbiter.md
Name: rr_mux_select_arbiter

Overview:
- Round-robin arbiter that generates the 2-bit select for the 4:1 decoder-driven tristate mux.
- Four sources request the shared mux output. The block grants one source at a time, for at most BURST_LEN cycles, then rotates fairly.
- Drives the mux select (sel), a one-hot grant back to the sources, and a valid flag that qualifies the mux output downstream.

Parameters:
- BURST_LEN, 4, maximum consecutive cycles one source may hold the grant (legal range 1..2**CNT_W-1).
- CNT_W, 3, width of the internal burst counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; 0 forces release and blocks new grants.
- req  input  4  request per source; req[k] corresponds to mux input ik.
- sel  output  2  encoded index of the granted source; drives the mux select d.
- gnt  output  4  one-hot grant, equal to (1 << sel) when gnt_valid=1, else 4'b0000.
- gnt_valid  output  1  1 while a grant is active; qualifies the mux output y.
- burst_done  output  1  one-cycle pulse in the cycle after a grant ended because it reached BURST_LEN.

Behaviour:
- Reset: on rst_n=0, immediately (no clock needed) set sel=0, gnt=0, gnt_valid=0, burst_done=0, ptr=0, count=0, state=IDLE.
- All outputs are registered; none has a combinational path from req or en.
- Priority search: from a set of requests, pick the first asserted req[k] in the order ptr, ptr+1, ptr+2, ptr+3, all indices mod 4.
- State machine, two states:
  - IDLE: gnt_valid=0, gnt=0, sel holds its last value. When en=1 and req!=0 at a rising edge: load sel=winner, gnt=onehot(winner), gnt_valid=1, count=1, go to GRANT.
  - GRANT: a release is due when any of the following holds: req[sel]=0; count==BURST_LEN; en=0. If no release is due: count <= count+1.
- On release:
  - ptr <= sel+1 mod 4.
  - Re-run the priority search on the current req, starting from sel+1 and with req[sel] masked only if req[sel]=0. A source that reached its limit may therefore be re-granted, but only after all other requesters.
  - If en=1 and a winner exists: load the new grant directly with count=1, stay in GRANT; gnt_valid stays 1, so there is no idle bubble.
  - Otherwise: gnt_valid=0, gnt=0, go to IDLE.
- burst_done is registered 1 for exactly one cycle when the release cause was count==BURST_LEN. It is 0 when the release was caused only by req drop or en=0.
- Latency: a req rising while in IDLE produces gnt_valid=1 at the next rising edge (1 cycle).
- BURST_LEN=1: every grant lasts exactly one cycle; under constant requests, sources rotate every cycle.
- en=0 in IDLE: remain in IDLE regardless of req.
- The counter never exceeds BURST_LEN and never wraps.
- A req change in the same cycle as a release: the search uses the sampled req of that cycle.

Test Plan:
- Reset check: rst_n=0 for 3 cycles with req=4'b1111, en=1 -> sel=0, gnt=0, gnt_valid=0, burst_done=0. Then assert rst_n=0 mid-grant between clock edges -> all outputs 0 before the next edge.
- Single requester, BURST_LEN=4: req=4'b0100 held, en=1 -> 1 cycle later sel=2, gnt=4'b0100, gnt_valid=1. After 4 grant cycles burst_done pulses once and source 2 is re-granted back-to-back; gnt_valid never drops.
- Full load: req=4'b1111 from reset -> grants go to 0,1,2,3,0, each lasting 4 cycles, with burst_done pulsing at each handover and no gap in gnt_valid.
- Early drop: source 1 granted with req=4'b1010; req[1] drops after 2 grant cycles -> next edge sel=3, gnt=4'b1000, burst_done=0.
- Enable: en=0 mid-grant -> next edge gnt_valid=0, gnt=0, sel unchanged. en back to 1 with req=4'b0001 -> grant to 0 one cycle later.
- BURST_LEN=1 build: req=4'b0011 -> sel alternates 0,1,0,1 every cycle, and burst_done stays 1 on every cycle after the first grant cycle.
